regs_mp: RTL and testbench
==========================

// Module: regs_mp
// PURPOSE
//  Parametrised multi-port integer register file with a per-register pending-write scoreboard.
//  Provides NRD combinational read ports with write-back bypass, and NWR write ports.
//  Contains a post-reset clear engine that zeroes every register before use.
//  Sits between decode/issue (reads, allocates pending writes) and write-back (retires writes).
// PARAMETERS
//  XLEN  32  data width of each register
//  NREGS 32  number of architectural registers (power of two)
//  AW    5   address width, log2(NREGS)
//  NRD   2   number of read ports
//  NWR   2   number of write ports
//  ZERO0 1   1: register 0 is hard-wired zero, never written, never busy
// PORTS
//  clk        in   1         clock, all state updates on posedge
//  rst        in   1         asynchronous, active-low reset
//  r_addr     in   NRD*AW    read addresses, port i at [i*AW +: AW]
//  r_data     out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
//  r_busy     out  NRD       1 = register read on port i still has a pending write
//  w_en       in   NWR       write enables
//  w_addr     in   NWR*AW    write addresses
//  w_data     in   NWR*XLEN  write data
//  alloc_en   in   1         issue stage marks alloc_addr as pending-write
//  alloc_addr in   AW        register being allocated
//  init_done  out  1         1 = clear engine finished, file usable
// BEHAVIOUR
//  Reset (rst=0, asynchronous): init_done=0, busy[] all 0, clear counter=0, FSM -> CLEAR.
//   Register contents are not reset directly; the clear engine zeroes them.
//  FSM: CLEAR -> READY.
//   CLEAR: one register per cycle, regs[cnt]<=0, cnt++. After cnt=NREGS-1 is written, go to READY.
//    init_done rises on the edge after the last clear, NREGS cycles after rst deasserts.
//   READY: terminal until the next reset.
//  During CLEAR: w_en and alloc_en are ignored, r_data=0, r_busy=0.
//  Reset asserted mid-CLEAR or in READY restarts the clear from cnt=0.
//  Write (READY): on posedge, regs[w_addr[j]]<=w_data[j] for each j with w_en[j].
//   Address 0 is dropped when ZERO0=1.
//   Two ports writing the same address in one cycle: the highest-index port wins.
//  Read (combinational, zero latency):
//   r_data[i] = data of the highest-index j with w_en[j] && w_addr[j]==r_addr[i], else regs[r_addr[i]].
//   The bypass is never taken for addr 0 when ZERO0=1; that read always returns 0.
//  Scoreboard (READY):
//   alloc_en sets busy[alloc_addr]; any w_en[j] clears busy[w_addr[j]].
//   Set and clear of the same address in one cycle: set wins (new producer issued).
//   busy[0] is held at 0 when ZERO0=1.
//   r_busy[i] = busy[r_addr[i]] & ~(any w_en[j] to r_addr[i] this cycle). This is consistent with the bypass.
//  Widths: no arithmetic; counter is AW+1 bits to detect terminal count.
// TESTING
//  1. Reset, then release rst -> init_done=0 for exactly 32 cycles, then 1. All r_data=0 afterwards.
//  2. Write x5=0xDEADBEEF on port 0, read x5 on port 1 the same cycle -> 0xDEADBEEF (bypass).
//     Next cycle, with no write -> 0xDEADBEEF from the array.
//  3. Same cycle: port0 writes x7=0x11, port1 writes x7=0x22 -> read x7 returns 0x22 now and afterwards.
//  4. Write x0=0xFFFFFFFF -> read x0 returns 0. alloc x0 -> r_busy stays 0.
//  5. alloc x3 -> r_busy=1 next cycle. Write x3=0x5 -> r_busy=0 in that cycle.
//     alloc x3 together with write x3 -> busy remains 1.
//  6. Pull rst low at clear cycle 10, release -> init_done takes 32 more cycles.
//     A write during CLEAR is lost; the register reads 0.

Source files
------------

// File: rtl/regs_mp.sv
// Multi-port register file with write-back bypass, a pending-write scoreboard,
// and a post-reset engine that zeroes every register before the file is usable.
module regs_mp #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   parameter int ZERO0 = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   r_addr,
   output logic [NRD*XLEN-1:0] r_data,
   output logic [NRD-1:0]      r_busy,
   input  logic [NWR-1:0]      w_en,
   input  logic [NWR*AW-1:0]   w_addr,
   input  logic [NWR*XLEN-1:0] w_data,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_addr,
   output logic                init_done
);

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_t;

   localparam logic [AW:0] LAST_REG = (AW + 1)'(NREGS - 1);

   state_t           state;
   state_t           state_next;
   logic [AW:0]      cnt;
   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_next;
   logic             ready;

   // Register 0 is treated as a constant zero source when ZERO0 is set.
   function automatic logic is_zero_reg(input logic [AW-1:0] a);
      return (ZERO0 != 0) && (a == '0);
   endfunction

   assign ready     = (state == ST_READY);
   assign init_done = ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_CLEAR;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_CLEAR: if (cnt == LAST_REG) state_next = ST_READY;
         ST_READY: state_next = ST_READY;
         default:  state_next = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (state == ST_CLEAR) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Storage has no reset of its own; the clear engine owns it until READY.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         regs[cnt[AW-1:0]] <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (w_en[j] && !is_zero_reg(w_addr[j*AW +: AW])) begin
               regs[w_addr[j*AW +: AW]] <= w_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   // Allocation is applied after retirement so a new producer keeps the bit set.
   always_comb begin
      busy_next = busy;
      if (ready) begin
         for (int j = 0; j < NWR; j++) begin
            if (w_en[j]) busy_next[w_addr[j*AW +: AW]] = 1'b0;
         end
         if (alloc_en) busy_next[alloc_addr] = 1'b1;
      end
      if (ZERO0 != 0) busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   always_comb begin
      r_data = '0;
      r_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         r_data[i*XLEN +: XLEN] = regs[r_addr[i*AW +: AW]];
         r_busy[i]              = busy[r_addr[i*AW +: AW]];
         for (int j = 0; j < NWR; j++) begin
            if (w_en[j] && (w_addr[j*AW +: AW] == r_addr[i*AW +: AW])) begin
               r_data[i*XLEN +: XLEN] = w_data[j*XLEN +: XLEN];
               r_busy[i]              = 1'b0;
            end
         end
         if (!ready || is_zero_reg(r_addr[i*AW +: AW])) begin
            r_data[i*XLEN +: XLEN] = '0;
            r_busy[i]              = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_regs_mp.sv
// Directed bench for regs_mp: clear-engine timing, bypass, port priority,
// register-zero handling, scoreboard set/clear and reset during clear.
module tb_regs_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  r_addr;
   logic [63:0] r_data;
   logic [1:0]  r_busy;
   logic [1:0]  w_en;
   logic [9:0]  w_addr;
   logic [63:0] w_data;
   logic        alloc_en;
   logic [4:0]  alloc_addr;
   logic        init_done;

   int compared = 0;
   int mismatched = 0;

   typedef struct packed {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        al;
      logic [4:0]  aa;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [1:0]  eb;
   } vec_t;

   vec_t vecs [16];

   regs_mp dut (
      .clk        (clk),
      .rst        (rst),
      .r_addr     (r_addr),
      .r_data     (r_data),
      .r_busy     (r_busy),
      .w_en       (w_en),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .init_done  (init_done)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic al, input logic [4:0] aa,
                               input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
      vec_t v;
      v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
      v.al = al; v.aa = aa; v.ra0 = ra0; v.ra1 = ra1;
      v.e0 = e0; v.e1 = e1; v.eb = eb;
      return v;
   endfunction

   task automatic apply_stimulus(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic al, input logic [4:0] aa,
                                 input logic [4:0] ra0, input logic [4:0] ra1);
      w_en       = we;
      w_addr     = {wa1, wa0};
      w_data     = {wd1, wd0};
      alloc_en   = al;
      alloc_addr = aa;
      r_addr     = {ra1, ra0};
   endtask

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (!init_done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 2) apply_stimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd5);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;

      // Expected results worked out by hand from the register-file behaviour.
      vecs[0]  = mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
      vecs[1]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h0,        2'b00);
      vecs[2]  = mk(2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5, 32'h22,       32'hDEADBEEF, 2'b00);
      vecs[3]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd7, 32'h22,       32'h22,       2'b00);
      vecs[4]  = mk(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00);
      vecs[5]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00);
      vecs[6]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd3, 32'h0,        32'h0,        2'b00);
      vecs[7]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd3, 32'h0,        32'h0,        2'b11);
      vecs[8]  = mk(2'b10, 5'd0, 32'h0,        5'd3, 32'h5,  1'b0, 5'd0, 5'd3, 5'd0, 32'h5,        32'h0,        2'b00);
      vecs[9]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd3, 32'h5,        32'h5,        2'b00);
      vecs[10] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd3, 32'h5,        32'h5,        2'b00);
      vecs[11] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd3, 32'h5,        32'h5,        2'b11);
      vecs[12] = mk(2'b01, 5'd3, 32'h9,        5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd4, 32'h9,        32'h0,        2'b00);
      vecs[13] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd4, 32'h9,        32'h0,        2'b01);
      vecs[14] = mk(2'b01, 5'd4, 32'hAA,       5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd3, 32'hAA,       32'h9,        2'b10);
      vecs[15] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd4, 32'h9,        32'hAA,       2'b01);

      rst = 1'b0;
      apply_stimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd31);
      #12;
      check_output("reset init_done", {31'd0, init_done}, 32'd0);
      check_output("reset r_data0", r_data[31:0], 32'd0);
      check_output("reset r_busy", {30'd0, r_busy}, 32'd0);

      // Release reset one unit after an edge and count edges until ready.
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_init(n);
      check_output("init cycles", n, 32'd32);
      check_output("init r_data0 x1", r_data[31:0], 32'd0);
      check_output("init r_data1 x31", r_data[63:32], 32'd0);

      for (int k = 0; k < 16; k++) begin
         apply_stimulus(vecs[k].we, vecs[k].wa0, vecs[k].wd0, vecs[k].wa1, vecs[k].wd1,
                        vecs[k].al, vecs[k].aa, vecs[k].ra0, vecs[k].ra1);
         #1;
         check_output($sformatf("v%0d r_data0", k), r_data[31:0], vecs[k].e0);
         check_output($sformatf("v%0d r_data1", k), r_data[63:32], vecs[k].e1);
         check_output($sformatf("v%0d r_busy", k), {30'd0, r_busy}, {30'd0, vecs[k].eb});
         check_output($sformatf("v%0d init_done", k), {31'd0, init_done}, 32'd1);
         @(posedge clk);
         #1;
      end

      // Reset from READY, then again part-way through the clear.
      apply_stimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd5);
      rst = 1'b0;
      #1;
      check_output("ready reset init_done", {31'd0, init_done}, 32'd0);
      check_output("ready reset r_busy", {30'd0, r_busy}, 32'd0);
      rst = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
      end
      check_output("mid clear init_done", {31'd0, init_done}, 32'd0);
      rst = 1'b0;
      #1;
      rst = 1'b1;
      apply_stimulus(2'b01, 5'd9, 32'h1234, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9);
      #1;
      check_output("clear bypass r_data0", r_data[31:0], 32'd0);
      check_output("clear r_busy", {30'd0, r_busy}, 32'd0);
      wait_init(n);
      check_output("restart init cycles", n, 32'd32);
      #1;
      check_output("lost write x9", r_data[31:0], 32'd0);
      check_output("recleared x5", r_data[63:32], 32'd0);
      check_output("lost alloc x9", {30'd0, r_busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
